run_controller: RTL

Sequences one program run of the single-cycle core: accepts the `start` pulse and start address, loads the PC, enables execution, counts retired (dynamic) instructions, detects the halt instruction and raises `done`. Sits in `TopLevel` between the bench/host pins (`start`, `start_addr`, `done`) and the fetch/PC and register/memory write-enable logic; `InstrCount` is sourced from this block.

---
 rtl/core_ctrl_pkg.sv | 14 +
 rtl/run_controller_if.sv | 33 +++
 rtl/sat_counter.sv | 26 ++
 rtl/run_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and default widths for the core run controller and its neighbours.
package core_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } run_state_t;

endpackage

// File: rtl/run_controller_if.sv
// Host/core-facing signal bundle of the run controller; run_state is a debug view of the FSM.
interface run_controller_if #(
    parameter int ADDR_W = core_ctrl_pkg::ADDR_W,
    parameter int CNT_W  = core_ctrl_pkg::CNT_W
);
    import core_ctrl_pkg::*;

    // Handshake: start is a request level, taken only in IDLE or DONE (so a held level
    // is taken once per run); done is the completion flag, held until the next taken start.
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              retire;
    logic              halt_instr;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              core_en;
    logic [CNT_W-1:0]  InstrCount;
    logic              halt;
    logic              timeout;
    logic              done;
    run_state_t        run_state;

    modport master (
        input  start, start_addr, retire, halt_instr,
        output pc_load, pc_load_val, core_en, InstrCount, halt, timeout, done, run_state
    );

    modport slave (
        output start, start_addr, retire, halt_instr,
        input  pc_load, pc_load_val, core_en, InstrCount, halt, timeout, done, run_state
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at LIMIT; sat flags the held top value.
module sat_counter #(
    parameter int           W     = 8,
    parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = (count == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences one program run: load PC, enable the core, count retires, stop on HALT or watchdog.
module run_controller #(
    parameter int ADDR_W     = core_ctrl_pkg::ADDR_W,
    parameter int CNT_W      = core_ctrl_pkg::CNT_W,
    parameter int MAX_CYCLES = 65535
) (
    input  logic             CLK,
    input  logic             Reset,
    run_controller_if.master bus
);
    import core_ctrl_pkg::*;

    localparam int               CYC_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

    run_state_t       state;
    logic             run_active;
    logic             start_accept;
    logic             halting;
    logic             wd_expire;
    logic [CNT_W-1:0] instr_count;
    logic             instr_sat;
    logic [CYC_W-1:0] cyc_count;
    logic             cyc_last;

    assign run_active   = (state == RUN);
    assign start_accept = bus.start && ((state == IDLE) || (state == DONE));
    assign halting      = run_active && bus.retire && bus.halt_instr;
    assign wd_expire    = run_active && cyc_last;

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .clr   (start_accept),
        .inc   (run_active && bus.retire && !instr_sat),
        .count (instr_count),
        .sat   (instr_sat)
    );

    // The watchdog counter parks on the last permitted RUN cycle, so its flag is the expiry.
    sat_counter #(.W(CYC_W), .LIMIT(CYC_LAST)) u_cycle_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .clr   (start_accept),
        .inc   (run_active),
        .count (cyc_count),
        .sat   (cyc_last)
    );

    assign bus.InstrCount = instr_count;
    assign bus.run_state  = state;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            bus.pc_load     <= 1'b0;
            bus.pc_load_val <= '0;
            bus.core_en     <= 1'b0;
            bus.halt        <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state           <= LOAD;
                        bus.pc_load     <= 1'b1;
                        bus.pc_load_val <= bus.start_addr;
                        bus.core_en     <= 1'b0;
                        bus.halt        <= 1'b0;
                        bus.timeout     <= 1'b0;
                        bus.done        <= 1'b0;
                    end
                end
                LOAD: begin
                    state       <= RUN;
                    bus.pc_load <= 1'b0;
                    bus.core_en <= 1'b1;
                end
                RUN: begin
                    // HALT takes priority when it lands on the watchdog's last cycle.
                    if (halting) begin
                        state       <= DONE;
                        bus.core_en <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.halt    <= 1'b1;
                    end else if (wd_expire) begin
                        state       <= DONE;
                        bus.core_en <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.timeout <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.pc_load <= 1'b0;
                    bus.core_en <= 1'b0;
                    bus.done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
